// File: rtl/fpu_issue_seq.sv
// Single-issue FPU sequencer: starts one functional unit, counts its fixed latency,
// captures the result and hands it to writeback. Optional flush port under FPU_FLUSH_EN.
module fpu_issue_seq #(
    parameter int BUS_WIDTH  = 64,
    parameter int FPU_OP_LEN = 6,
    parameter int ADD_LAT    = 3,
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 12,
    parameter int SQRT_LAT   = 16,
    parameter int MISC_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FPU_OP_LEN-1:0] in_op,
    input  logic                  in_rd_fp,
    input  logic [4:0]            in_rd_addr,
    output logic                  unit_start,
    output logic [2:0]            unit_sel,
    output logic [FPU_OP_LEN-1:0] unit_op,
    input  logic [BUS_WIDTH-1:0]  unit_result,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [BUS_WIDTH-1:0]  wb_data,
    output logic                  wb_fp,
    output logic [4:0]            wb_rd,
`ifdef FPU_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  illegal,
    output logic                  busy
);

    localparam int MAX_A   = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int MAX_B   = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_LAT = (MAX_C > MISC_LAT) ? MAX_C : MISC_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FPU_OP_LEN-1:0]   op_q, op_d;
    logic [2:0]              sel_q, sel_d;
    logic                    fp_q, fp_d;
    logic [4:0]              rd_q, rd_d;
    logic [BUS_WIDTH-1:0]    data_q, data_d;

    logic                    flush_w;
    logic [2:0]              dec_sel;
    logic [CNT_W-1:0]        dec_cnt;
    logic                    dec_illegal;

`ifdef FPU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Op-class decode; 001010-001111 and all-ones are undecoded and rejected.
    always_comb begin
        dec_sel     = 3'd4;
        dec_cnt     = CNT_W'(MISC_LAT - 1);
        dec_illegal = 1'b0;
        if (in_op < FPU_OP_LEN'(4)) begin
            dec_sel = 3'd0;
            dec_cnt = CNT_W'(ADD_LAT - 1);
        end else if (in_op < FPU_OP_LEN'(6)) begin
            dec_sel = 3'd1;
            dec_cnt = CNT_W'(MUL_LAT - 1);
        end else if (in_op < FPU_OP_LEN'(8)) begin
            dec_sel = 3'd2;
            dec_cnt = CNT_W'(DIV_LAT - 1);
        end else if (in_op < FPU_OP_LEN'(10)) begin
            dec_sel = 3'd3;
            dec_cnt = CNT_W'(SQRT_LAT - 1);
        end else if (in_op < FPU_OP_LEN'(16) || in_op == '1) begin
            dec_illegal = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sel_d      = sel_q;
        fp_d       = fp_q;
        rd_d       = rd_q;
        data_d     = data_q;
        in_ready   = 1'b0;
        unit_start = 1'b0;
        illegal    = 1'b0;
        unit_sel   = sel_q;
        unit_op    = op_q;
        case (state_q)
            IDLE: begin
                in_ready = !flush_w;
                if (in_valid && !flush_w) begin
                    if (dec_illegal) begin
                        illegal = 1'b1;
                    end else begin
                        unit_start = 1'b1;
                        unit_sel   = dec_sel;
                        unit_op    = in_op;
                        sel_d      = dec_sel;
                        op_d       = in_op;
                        fp_d       = in_rd_fp;
                        rd_d       = in_rd_addr;
                        cnt_d      = dec_cnt;
                        state_d    = EXEC;
                    end
                end
            end
            EXEC: begin
                if (flush_w) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    data_d  = unit_result;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WB: begin
                if (flush_w || wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sel_q   <= '0;
            fp_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            fp_q    <= fp_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign wb_valid = (state_q == WB);
    assign busy     = (state_q != IDLE);
    assign wb_data  = data_q;
    assign wb_fp    = fp_q;
    assign wb_rd    = rd_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Scoreboard bench for fpu_issue_seq: latency, handshake, illegal ops, reset and flush.
module tb_fpu_issue_seq;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic        in_rd_fp = 0;
    logic [4:0]  in_rd_addr = '0;
    logic        unit_start;
    logic [2:0]  unit_sel;
    logic [5:0]  unit_op;
    logic [63:0] unit_result = '0;
    logic        wb_valid;
    logic        wb_ready = 0;
    logic [63:0] wb_data;
    logic        wb_fp;
    logic [4:0]  wb_rd;
    logic        illegal;
    logic        busy;
`ifdef FPU_FLUSH_EN
    logic        flush = 0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] d;
        logic        fp;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb[$];

    fpu_issue_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd_fp(in_rd_fp), .in_rd_addr(in_rd_addr),
        .unit_start(unit_start), .unit_sel(unit_sel), .unit_op(unit_op),
        .unit_result(unit_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_fp(wb_fp), .wb_rd(wb_rd),
`ifdef FPU_FLUSH_EN
        .flush(flush),
`endif
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [5:0] op);
        if (op <= 6'd3) return 3;
        if (op <= 6'd5) return 4;
        if (op <= 6'd7) return 12;
        if (op <= 6'd9) return 16;
        return 1;
    endfunction

    function automatic logic [2:0] exp_sel(input logic [5:0] op);
        if (op <= 6'd3) return 3'd0;
        if (op <= 6'd5) return 3'd1;
        if (op <= 6'd7) return 3'd2;
        if (op <= 6'd9) return 3'd3;
        return 3'd4;
    endfunction

    function automatic bit exp_ill(input logic [5:0] op);
        return (op == 6'h3f) || (op >= 6'd10 && op <= 6'd15);
    endfunction

    task automatic issue(input logic [5:0] op, input logic fp, input logic [4:0] rd,
                         input logic [63:0] res);
        bit st;
        st = !exp_ill(op);
        in_valid = 1; in_op = op; in_rd_fp = fp; in_rd_addr = rd; unit_result = res;
        #1;
        checks++;
        if (in_ready !== 1'b1 || unit_start !== st || illegal !== !st ||
            (st && (unit_sel !== exp_sel(op) || unit_op !== op))) begin
            errors++;
            $display("FAIL accept op=%b: ready=%b start=%b ill=%b sel=%0d uop=%b, want ready=1 start=%b ill=%b sel=%0d",
                     op, in_ready, unit_start, illegal, unit_sel, unit_op, st, !st, exp_sel(op));
        end
        if (st) sb.push_back('{d: res, fp: fp, rd: rd});
        @(posedge clk); #1;
        in_valid = 0;
        #1;
        checks++;
        if (unit_start !== 1'b0 || illegal !== 1'b0 || busy !== st) begin
            errors++;
            $display("FAIL post_accept op=%b: start=%b ill=%b busy=%b, want 0 0 %b",
                     op, unit_start, illegal, busy, st);
        end
    endtask

    task automatic wait_wb(input int lat, input bit poke, input int stall);
        int   n;
        bit   seen;
        exp_t e;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (wb_valid) seen = 1;
            else if (poke) begin
                in_valid = n[0]; in_op = 6'b000000;
                #1;
                checks++;
                if (unit_start !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL exec_stall cyc=%0d: start=%b ready=%b, want 0 0", n, unit_start, in_ready);
                end
            end
        end
        in_valid = 0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wb_timeout: no wb_valid within %0d cycles, want %0d", n, lat);
            return;
        end
        if (n !== lat) begin
            errors++;
            $display("FAIL latency: wb_valid after %0d cycles, want %0d", n, lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: wb_valid with no expected entry");
            return;
        end
        e = sb.pop_front();
        if (wb_data !== e.d || wb_fp !== e.fp || wb_rd !== e.rd) begin
            errors++;
            $display("FAIL wb_payload: data=%h fp=%b rd=%0d, want data=%h fp=%b rd=%0d",
                     wb_data, wb_fp, wb_rd, e.d, e.fp, e.rd);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== e.d || wb_rd !== e.rd || wb_fp !== e.fp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL wb_hold cyc=%0d: valid=%b data=%h rd=%0d fp=%b ready=%b, want 1 %h %0d %b 0",
                         i, wb_valid, wb_data, wb_rd, wb_fp, in_ready, e.d, e.rd, e.fp);
            end
        end
        wb_ready = 1;
        @(posedge clk); #1;
        wb_ready = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL wb_done: busy=%b ready=%b valid=%b, want 0 1 0", busy, in_ready, wb_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || unit_start !== 1'b0 ||
            illegal !== 1'b0 || wb_data !== 64'h0 || wb_rd !== 5'd0 || wb_fp !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b valid=%b start=%b ill=%b data=%h rd=%0d fp=%b, want 1 0 0 0 0 0 0 0",
                     in_ready, busy, wb_valid, unit_start, illegal, wb_data, wb_rd, wb_fp);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        issue(6'b000000, 1'b1, 5'd5, 64'h4008000000000000);
        wait_wb(3, 0, 0);
    endtask

    task automatic test_sqrt_poke;
        issue(6'b001001, 1'b1, 5'd17, 64'h3ff6a09e667f3bcd);
        wait_wb(16, 1, 0);
    endtask

    task automatic test_wb_stall;
        issue(6'b010100, 1'b0, 5'd10, 64'h0000000000000001);
        wait_wb(1, 0, 5);
    endtask

    task automatic test_illegal;
        logic [5:0] ops [2];
        ops[0] = 6'b111111; ops[1] = 6'b001100;
        foreach (ops[k]) begin
            issue(ops[k], 1'b1, 5'd3, 64'hdead);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                checks++;
                if (wb_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_idle op=%b: valid=%b ready=%b busy=%b ill=%b, want 0 1 0 0",
                             ops[k], wb_valid, in_ready, busy, illegal);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        issue(6'b000110, 1'b1, 5'd7, 64'h1234);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b busy=%b valid=%b data=%h, want 1 0 0 0",
                     in_ready, busy, wb_valid, wb_data);
        end
        sb.delete();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        issue(6'b000101, 1'b1, 5'd9, 64'h40a0000000000000);
        wait_wb(4, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [5:0] ops [6];
        ops[0] = 6'b000001; ops[1] = 6'b000100; ops[2] = 6'b010000;
        ops[3] = 6'b000111; ops[4] = 6'b100011; ops[5] = 6'b000010;
        foreach (ops[k]) begin
            issue(ops[k], k[0], 5'(k + 20), {$urandom, $urandom});
            wait_wb(exp_lat(ops[k]), 0, k % 3);
        end
    endtask

`ifdef FPU_FLUSH_EN
    task automatic test_flush;
        issue(6'b000110, 1'b1, 5'd4, 64'h5555);
        repeat (2) @(posedge clk);
        #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_exec: busy=%b valid=%b ready=%b, want 0 0 1", busy, wb_valid, in_ready);
        end
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_wb cyc=%0d: valid=%b, want 0", i, wb_valid);
            end
        end
        sb.delete();
        issue(6'b010000, 1'b0, 5'd8, 64'h7777);
        @(posedge clk); #1;
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_wb_pre: valid=%b, want 1", wb_valid);
        end
        flush = 1;
        @(posedge clk); #1;
        in_valid = 1; in_op = 6'b000000;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b0 || unit_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_block: valid=%b ready=%b start=%b busy=%b, want 0 0 0 0",
                     wb_valid, in_ready, unit_start, busy);
        end
        in_valid = 0;
        flush = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_wb_ready: ready=%b, want 1", in_ready);
        end
        sb.delete();
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sqrt_poke();
        test_wb_stall();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
`ifdef FPU_FLUSH_EN
        test_flush();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
